regfile_writeback_queue: RTL and testbench

- Write-side feeder for the 32 x 64-bit register file (X31 reads as zero).
- Accepts write-back requests from the execute/memory stages through a valid/ready handshake and buffers them in a small FIFO.
- Drains one entry per cycle onto the register file write port (RW, BusW, RegWr).
- Optional bypass lets readers see values that are queued but not yet committed.

---
 rtl/wbq_pkg.sv | 18 +
 rtl/wbq_match.sv | 32 +++
 rtl/regfile_writeback_queue.sv | 119 +++++++++++
 tb/tb_regfile_writeback_queue.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/wbq_pkg.sv
// Shared types and helpers for the register-file write-back queue.
package wbq_pkg;

  localparam int unsigned WbqAw    = 5;
  localparam int unsigned WbqWidth = 64;

  localparam logic [WbqAw-1:0] XZR_IDX = 5'd31;

  typedef struct packed {
    logic [WbqAw-1:0]    rd;
    logic [WbqWidth-1:0] data;
  } wb_entry_t;

  function automatic logic is_xzr(input logic [WbqAw-1:0] idx);
    return idx == XZR_IDX;
  endfunction

endpackage

// File: rtl/wbq_match.sv
// Youngest-match lookup over the valid entries of the write-back queue.
module wbq_match
  import wbq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PW    = $clog2(DEPTH)
) (
  input  wb_entry_t             entries [DEPTH],
  input  logic [DEPTH-1:0]      valid,
  input  logic [PW-1:0]         head,
  input  logic [WbqAw-1:0]      idx,
  output logic                  hit,
  output logic [WbqWidth-1:0]   data
);

  logic [PW-1:0] slot;

  // Walk oldest to youngest so the last match (the youngest) wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    slot = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      slot = head + PW'(k);
      if (valid[slot] && entries[slot].rd == idx) begin
        hit  = 1'b1;
        data = entries[slot].data;
      end
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// FIFO feeding the register-file write port; one commit per cycle.
// Optional read bypass of queued/committing values under WBQ_BYPASS_EN.
module regfile_writeback_queue
  import wbq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned AW    = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [AW-1:0]    InRd,
  input  logic [WIDTH-1:0] InData,
  input  logic             RegFileHold,
  output logic [AW-1:0]    RW,
  output logic [WIDTH-1:0] BusW,
  output logic             RegWr,
  output logic             Empty,
  input  logic [AW-1:0]    RA,
  input  logic [AW-1:0]    RB,
  output logic             HitA,
  output logic             HitB,
  output logic [WIDTH-1:0] FwdA,
  output logic [WIDTH-1:0] FwdB
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_entry_t     entries_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic          push, pop;

  assign InReady = count_q != CW'(DEPTH);
  assign Empty   = count_q == '0;
  // XZR writes complete the handshake but are dropped here.
  assign push    = InValid && InReady && !is_xzr(InRd);
  assign pop     = (count_q != '0) && !RegFileHold;

  always_ff @(posedge Clk) begin
    if (push) begin
      entries_q[tail_q] <= '{rd: InRd, data: InData};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      RegWr   <= 1'b0;
      RW      <= '0;
      BusW    <= '0;
    end else begin
      RegWr <= pop;
      if (push) begin
        tail_q <= tail_q + PW'(1);
      end
      if (pop) begin
        RW     <= entries_q[head_q].rd;
        BusW   <= entries_q[head_q].data;
        head_q <= head_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef WBQ_BYPASS_EN
  logic [DEPTH-1:0] valid;
  logic             q_hit_a, q_hit_b;
  logic [WIDTH-1:0] q_data_a, q_data_b;

  // Slot i is live when its distance from head is below count.
  always_comb begin
    valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid[i] = {1'b0, PW'(i) - head_q} < count_q;
    end
  end

  wbq_match #(.DEPTH(DEPTH)) u_match_a (
    .entries (entries_q),
    .valid   (valid),
    .head    (head_q),
    .idx     (RA),
    .hit     (q_hit_a),
    .data    (q_data_a)
  );

  wbq_match #(.DEPTH(DEPTH)) u_match_b (
    .entries (entries_q),
    .valid   (valid),
    .head    (head_q),
    .idx     (RB),
    .hit     (q_hit_b),
    .data    (q_data_b)
  );

  assign HitA = !is_xzr(RA) && (q_hit_a || (RegWr && RW == RA));
  assign HitB = !is_xzr(RB) && (q_hit_b || (RegWr && RW == RB));
  assign FwdA = !HitA ? '0 : (q_hit_a ? q_data_a : BusW);
  assign FwdB = !HitB ? '0 : (q_hit_b ? q_data_b : BusW);
`else
  logic unused_read_idx;
  assign unused_read_idx = ^{RA, RB};
  assign HitA = 1'b0;
  assign HitB = 1'b0;
  assign FwdA = '0;
  assign FwdB = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue: vector table plus scoreboarded FIFO model.
module tb_regfile_writeback_queue;

  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [4:0]  InRd = '0;
  logic [63:0] InData = '0;
  logic        RegFileHold = 1'b0;
  logic [4:0]  RW;
  logic [63:0] BusW;
  logic        RegWr;
  logic        Empty;
  logic [4:0]  RA = 5'd5;
  logic [4:0]  RB = 5'd2;
  logic        HitA, HitB;
  logic [63:0] FwdA, FwdB;

  always #5 Clk = ~Clk;

  regfile_writeback_queue #(.DEPTH(DEPTH), .WIDTH(64), .AW(5)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .InValid     (InValid),
    .InReady     (InReady),
    .InRd        (InRd),
    .InData      (InData),
    .RegFileHold (RegFileHold),
    .RW          (RW),
    .BusW        (BusW),
    .RegWr       (RegWr),
    .Empty       (Empty),
    .RA          (RA),
    .RB          (RB),
    .HitA        (HitA),
    .HitB        (HitB),
    .FwdA        (FwdA),
    .FwdB        (FwdB)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;

  typedef struct {
    bit          v;
    logic [4:0]  rd;
    logic [63:0] d;
    bit          hold;
    bit          rst;
    bit          e_ready;
    bit          e_empty;
    bit          e_regwr;
  } vec_t;

  ent_t        fifo_m[$];
  logic        m_regwr = 1'b0;
  logic [4:0]  m_rw = '0;
  logic [63:0] m_busw = '0;
  int          n_checks = 0;
  int          n_fail = 0;
  vec_t        tbl[21];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_fwd(input logic [4:0] idx, output logic hit, output logic [63:0] d);
    hit = 1'b0;
    d   = '0;
`ifdef WBQ_BYPASS_EN
    if (idx != 5'd31) begin
      if (m_regwr && m_rw == idx) begin
        hit = 1'b1;
        d   = m_busw;
      end
      foreach (fifo_m[i]) begin
        if (fifo_m[i].rd == idx) begin
          hit = 1'b1;
          d   = fifo_m[i].data;
        end
      end
    end
`endif
  endtask

  // One clock: drive, update model at the edge, compare on the falling edge.
  task automatic step(input bit v, input logic [4:0] rd, input logic [63:0] d,
                      input bit hold, input bit rst);
    bit          acc, pop;
    ent_t        e;
    logic        eh;
    logic [63:0] ed;
    InValid = v; InRd = rd; InData = d; RegFileHold = hold; Reset = rst;
    @(posedge Clk);
    if (rst) begin
      fifo_m.delete();
      m_regwr = 1'b0; m_rw = '0; m_busw = '0;
    end else begin
      acc = v && (fifo_m.size() != DEPTH);
      pop = (fifo_m.size() != 0) && !hold;
      if (pop) begin
        e = fifo_m.pop_front();
        m_rw = e.rd;
        m_busw = e.data;
      end
      m_regwr = pop;
      if (acc && rd != 5'd31) fifo_m.push_back('{rd: rd, data: d});
    end
    @(negedge Clk);
    check("InReady", {63'd0, InReady}, {63'd0, fifo_m.size() != DEPTH});
    check("Empty", {63'd0, Empty}, {63'd0, fifo_m.size() == 0});
    check("RegWr", {63'd0, RegWr}, {63'd0, m_regwr});
    check("RW", {59'd0, RW}, {59'd0, m_rw});
    check("BusW", BusW, m_busw);
    exp_fwd(RA, eh, ed);
    check("HitA", {63'd0, HitA}, {63'd0, eh});
    check("FwdA", FwdA, ed);
    exp_fwd(RB, eh, ed);
    check("HitB", {63'd0, HitB}, {63'd0, eh});
    check("FwdB", FwdB, ed);
  endtask

  initial begin
    // Test 1: single write, then drain.
    tbl[0]  = '{1, 5'd5,  64'h1234, 0, 0, 1, 0, 0};
    tbl[1]  = '{0, 5'd0,  64'h0,    0, 0, 1, 1, 1};
    tbl[2]  = '{0, 5'd0,  64'h0,    0, 0, 1, 1, 0};
    // Test 2: fill under hold, reject fifth, drain in order.
    tbl[3]  = '{1, 5'd1,  64'd10,   1, 0, 1, 0, 0};
    tbl[4]  = '{1, 5'd2,  64'd11,   1, 0, 1, 0, 0};
    tbl[5]  = '{1, 5'd3,  64'd12,   1, 0, 1, 0, 0};
    tbl[6]  = '{1, 5'd4,  64'd13,   1, 0, 0, 0, 0};
    tbl[7]  = '{1, 5'd5,  64'd14,   1, 0, 0, 0, 0};
    tbl[8]  = '{0, 5'd0,  64'h0,    0, 0, 1, 0, 1};
    tbl[9]  = '{0, 5'd0,  64'h0,    0, 0, 1, 0, 1};
    tbl[10] = '{0, 5'd0,  64'h0,    0, 0, 1, 0, 1};
    tbl[11] = '{0, 5'd0,  64'h0,    0, 0, 1, 1, 1};
    tbl[12] = '{0, 5'd0,  64'h0,    0, 0, 1, 1, 0};
    // Test 3: XZR write is swallowed.
    tbl[13] = '{1, 5'd31, 64'hFFFF, 0, 0, 1, 1, 0};
    tbl[14] = '{0, 5'd0,  64'h0,    0, 0, 1, 1, 0};
    // Test 5: reset discards pending entries.
    tbl[15] = '{1, 5'd8,  64'd20,   1, 0, 1, 0, 0};
    tbl[16] = '{1, 5'd9,  64'd21,   1, 0, 1, 0, 0};
    tbl[17] = '{1, 5'd10, 64'd22,   1, 0, 1, 0, 0};
    tbl[18] = '{0, 5'd0,  64'h0,    1, 1, 1, 1, 0};
    tbl[19] = '{0, 5'd0,  64'h0,    0, 0, 1, 1, 0};
    tbl[20] = '{0, 5'd0,  64'h0,    0, 0, 1, 1, 0};

    step(0, 5'd0, 64'h0, 0, 1);
    step(0, 5'd0, 64'h0, 0, 1);
    check("reset_RegWr", {63'd0, RegWr}, 64'd0);
    check("reset_RW", {59'd0, RW}, 64'd0);
    check("reset_BusW", BusW, 64'd0);
    check("reset_Empty", {63'd0, Empty}, 64'd1);
    check("reset_InReady", {63'd0, InReady}, 64'd1);

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].v, tbl[i].rd, tbl[i].d, tbl[i].hold, tbl[i].rst);
      check($sformatf("tbl%0d_ready", i), {63'd0, InReady}, {63'd0, tbl[i].e_ready});
      check($sformatf("tbl%0d_empty", i), {63'd0, Empty}, {63'd0, tbl[i].e_empty});
      check($sformatf("tbl%0d_regwr", i), {63'd0, RegWr}, {63'd0, tbl[i].e_regwr});
      if (i == 1) begin
        check("t1_RW", {59'd0, RW}, 64'd5);
        check("t1_BusW", BusW, 64'h1234);
      end
    end

    // Test 4: same register queued twice; younger value forwarded, both commit.
    RA = 5'd7; RB = 5'd31;
    step(1, 5'd7, 64'hA, 1, 0);
    step(1, 5'd7, 64'hB, 1, 0);
`ifdef WBQ_BYPASS_EN
    check("t4_HitA", {63'd0, HitA}, 64'd1);
    check("t4_FwdA", FwdA, 64'hB);
`else
    check("t4_HitA", {63'd0, HitA}, 64'd0);
    check("t4_FwdA", FwdA, 64'h0);
`endif
    check("t4_HitB", {63'd0, HitB}, 64'd0);
    step(0, 5'd0, 64'h0, 0, 0);
    check("t4_first_RW", {59'd0, RW}, 64'd7);
    check("t4_first_BusW", BusW, 64'hA);
    step(0, 5'd0, 64'h0, 0, 0);
    check("t4_second_BusW", BusW, 64'hB);
    check("t4_second_RegWr", {63'd0, RegWr}, 64'd1);
    step(0, 5'd0, 64'h0, 0, 0);
    check("t4_done_RegWr", {63'd0, RegWr}, 64'd0);

    // Test 6: streaming past the pointer wrap with no stall.
    RA = 5'd3; RB = 5'd8;
    for (int i = 1; i <= 8; i++) begin
      step(1, 5'(i), 64'd100 + 64'(i), 0, 0);
      check($sformatf("t6_ready%0d", i), {63'd0, InReady}, 64'd1);
      if (i > 1) begin
        check($sformatf("t6_RW%0d", i), {59'd0, RW}, 64'(i - 1));
        check($sformatf("t6_BusW%0d", i), BusW, 64'd100 + 64'(i - 1));
      end
    end
    step(0, 5'd0, 64'h0, 0, 0);
    check("t6_last_RW", {59'd0, RW}, 64'd8);
    check("t6_last_BusW", BusW, 64'd108);
    step(0, 5'd0, 64'h0, 0, 0);
    check("t6_idle_RegWr", {63'd0, RegWr}, 64'd0);
    check("t6_idle_Empty", {63'd0, Empty}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
